// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, controller states and frame assembly.
// Pure package, no timing or flow control of its own.
// Parity generation is compiled in only when UART_PARITY_EN is defined; otherwise P is a mark bit.
package uart_pkg;

    localparam int                 FRAME_W    = 11;
    localparam int                 DATA_W     = 8;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_e;

    // Frame is shifted out LSB first: start(0), data, P, then mark bits up to FRAME_W.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [DATA_W-1:0] data,
        input logic              eight,
        input logic              pen,
        input logic              ohel
    );
        logic               par;
        logic [FRAME_W-1:0] frm;
`ifdef UART_PARITY_EN
        logic [DATA_W-1:0]  d_eff;
        // In 7-bit mode bit 7 must not contribute to parity.
        d_eff = eight ? data : {1'b0, data[6:0]};
        if (!pen) begin
            par = 1'b1;
        end else if (ohel) begin
            par = ~^d_eff;
        end else begin
            par = ^d_eff;
        end
`else
        logic               unused_par_cfg;
        // Without parity support P degenerates to a second stop bit.
        unused_par_cfg = pen ^ ohel;
        par            = 1'b1;
`endif
        if (eight) begin
            frm = {1'b1, par, data, 1'b0};
        end else begin
            frm = {1'b1, 1'b1, par, data[6:0], 1'b0};
        end
        return frm;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Modulo-BIT_TIME cycle counter with enable and synchronous clear; tick_o marks the terminal count.
// Latency: tick_o is combinational on the cycle the count equals BIT_TIME-1 while enabled.
// No backpressure: counts whenever en_i is high, clr_i has priority over en_i.
module uart_bit_timer #(
    parameter  int BIT_TIME = 5208,
    localparam int CNT_W    = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(BIT_TIME - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == TERM);

    // Next count: clear wins, otherwise wrap exactly at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: builds the 11-bit frame, loads the PISO register and paces one shift per bit time.
// Latency: ld one cycle after tx_start, first shift BIT_TIME cycles after ld, tx_done 11*BIT_TIME+2 after tx_start.
// tx_start is accepted only while tx_rdy is high; requests at other times are dropped. UART_PARITY_EN enables parity.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BIT_TIME = 5208
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_start,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               eight,
    input  logic               pen,
    input  logic               ohel,
    output logic [FRAME_W-1:0] frame,
    output logic               ld,
    output logic               shift,
    output logic               tx_rdy,
    output logic               tx_done
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_W);

    tx_state_e          state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ld_q, ld_d;
    logic               shift_q;
    logic               timer_en, timer_clr, bit_tick;

    uart_bit_timer #(
        .BIT_TIME (BIT_TIME)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .en_i   (timer_en),
        .clr_i  (timer_clr),
        .tick_o (bit_tick)
    );

    assign frame = frame_q;
    assign ld    = ld_q;
    assign shift = shift_q;

    // Next-state, frame capture and status outputs.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        ld_d      = 1'b0;
        timer_en  = 1'b0;
        timer_clr = 1'b0;
        tx_rdy    = 1'b0;
        tx_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_rdy    = 1'b1;
                timer_clr = 1'b1;
                if (tx_start) begin
                    frame_d   = build_frame(tx_data, eight, pen, ohel);
                    ld_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // Timer stops once all bit times have elapsed.
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end else begin
                    timer_en = 1'b1;
                    if (bit_tick) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                tx_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered strobes; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            frame_q   <= IDLE_FRAME;
            ld_q      <= 1'b0;
            shift_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            ld_q      <= ld_d;
            shift_q   <= bit_tick;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: directed and random stimulus, predictor queue plus decoupled checker.
// Expected frames and timing come from a frame-level model of the transmitter.
// Honours UART_PARITY_EN the same way the design does.
module tb_uart_tx_ctrl;

    localparam int BT      = 4;
    localparam int FRAME_T = 11 * BT + 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        eight = 1'b1;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic [10:0] frame;
    logic        ld, shift, tx_rdy, tx_done;

    uart_tx_ctrl #(.BIT_TIME(BT)) dut (
        .clk      (clk),
        .reset    (reset_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .frame    (frame),
        .ld       (ld),
        .shift    (shift),
        .tx_rdy   (tx_rdy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] frm;
        int          t;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   stim_timeouts = 0;
    bit   end_req = 0;
    bit   end_ack = 0;

    // Reference frame: start bit, data bits LSB first, parity, mark fill.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic o);
        logic [10:0] f;
        int nbits;
        int ones;
        int pb;
        nbits = e ? 8 : 7;
        ones  = 0;
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
`ifdef UART_PARITY_EN
        if (!p)     pb = 1;
        else if (o) pb = 1 - (ones % 2);
        else        pb = ones % 2;
`else
        pb = 1 + 0 * int'(p) + 0 * int'(o);
`endif
        f = 11'h7FF;
        f[0] = 1'b0;
        for (int i = 0; i < nbits; i++) f[1 + i] = d[i];
        f[1 + nbits] = pb[0];
        return f;
    endfunction

    // Predictor: models acceptance from cycle arithmetic and queues the expected frame.
    int idle_from = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            idle_from = 0;
        end else if (tx_start && cyc >= idle_from) begin
            q.push_back('{model_frame(tx_data, eight, pen, ohel), cyc});
            idle_from = cyc + FRAME_T + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Checker: pops on every ld and follows the frame through shifts to tx_done.
    bit in_flight = 0;
    int st_cyc = 0;
    int ld_cyc = 0;
    int nshift = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            chk("rst_frame", frame, 11'h7FF);
            chk("rst_ld", ld, 0);
            chk("rst_shift", shift, 0);
            chk("rst_done", tx_done, 0);
            chk("rst_rdy", tx_rdy, 1);
            in_flight = 0;
        end else begin
            chk("ld_shift_excl", ld & shift, 0);
            if (ld) begin
                chk("ld_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("frame", frame, e.frm);
                    chk("ld_latency", cyc - e.t, 1);
                    in_flight = 1;
                    st_cyc = e.t;
                    ld_cyc = cyc;
                    nshift = 0;
                end
            end
            if (shift) begin
                chk("shift_in_frame", in_flight, 1);
                if (in_flight) begin
                    chk("shift_time", cyc - ld_cyc, BT * (nshift + 1));
                    nshift++;
                end
            end
            chk("tx_rdy", tx_rdy, !in_flight);
            if (tx_done) begin
                chk("done_in_frame", in_flight, 1);
                if (in_flight) begin
                    chk("shift_count", nshift, 11);
                    chk("done_time", cyc - st_cyc, FRAME_T);
                end
                in_flight = 0;
            end
            if (in_flight && (cyc - st_cyc) > FRAME_T) begin
                chk("done_timeout", cyc - st_cyc, FRAME_T);
                in_flight = 0;
            end
            if (q.size() != 0 && cyc > q[0].t + 1) begin
                chk("ld_timeout", cyc - q[0].t, 1);
                q.delete(0);
            end
            if (end_req && !end_ack) begin
                chk("drain_queue", q.size(), 0);
                chk("drain_busy", in_flight, 0);
                chk("stim_timeouts", stim_timeouts, 0);
                end_ack = 1;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o);
        int w;
        w = 0;
        while (!tx_rdy && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!tx_rdy) stim_timeouts++;
        tx_data = d; eight = e; pen = p; ohel = o;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Data changes right after acceptance, then reset lands mid-frame.
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        tx_data = 8'h3C;
        do begin @(posedge clk); #1; end while (cyc < 20);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Parity and width variants.
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b1, 1'b1);
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1, 1'b0);
        send(8'h7F, 1'b0, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b1, 1'b1);

        // tx_start held high while inputs keep changing.
        send(8'h96, 1'b1, 1'b1, 1'b0);
        tx_start = 1'b1;
        for (int i = 0; i < 160; i++) begin
            tx_data = 8'($urandom);
            eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
            @(posedge clk); #1;
        end
        tx_start = 1'b0;

        // Random traffic with stray requests during frames.
        for (int i = 0; i < 2500; i++) begin
            tx_start = ($urandom_range(0, 11) == 0);
            tx_data = 8'($urandom);
            eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
            @(posedge clk); #1;
        end
        tx_start = 1'b0;
        repeat (FRAME_T + 8) @(posedge clk);
        #1 end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_handshake: checker did not respond");
            $fatal(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit controller for the Nexys2 UART. It sits directly upstream of the 11-bit parallel-in/serial-out transmit shift register and drives that register's Din, ld and shift inputs. The shift register's serial output, LSB first, is the TX line. The block assembles the frame (start, data, parity, stop), paces one shift per bit time, and reports ready/done to the host logic.

Parameters:
BIT_TIME, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be >= 2
CNT_W, $clog2(BIT_TIME), bit-time counter width (derived; do not override)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tx_start  input  1  one-cycle request to send tx_data; sampled only in IDLE
tx_data  input  8  byte to send
eight  input  1  1 = 8 data bits, 0 = 7 data bits (tx_data[7] ignored)
pen  input  1  parity enable
ohel  input  1  parity select: 1 = odd, 0 = even
frame  output  11  parallel frame to the shift register's Din
ld  output  1  one-cycle load strobe to the shift register
shift  output  1  one-cycle shift strobe, once per bit time
tx_rdy  output  1  high when idle and able to accept tx_start
tx_done  output  1  one-cycle pulse after the last bit time completes

Behaviour:
- Reset (async, active-low) state:
  - state = IDLE; bit-time and bit counters = 0.
  - frame = 11'h7FF; ld = 0; shift = 0; tx_done = 0; tx_rdy = 1.
  - Reset mid-frame aborts immediately; no tx_done is issued.
- Frame assembly is registered on acceptance:
  - eight=1: frame = {1, P, d[7:0], 0}.
  - eight=0: frame = {1, 1, P, d[6:0], 0}.
  - P: pen=0 gives 1. pen=1, ohel=0 gives ^data (even parity). pen=1, ohel=1 gives ~^data (odd parity).
  - data is d[7:0] or d[6:0] according to eight.
  - Bit 0 is always the start bit (0). Remaining unused high bits are 1 (idle/mark level).
- States:
  - IDLE:
    - tx_rdy = 1.
    - tx_start=1: register frame and assert ld for exactly one cycle in the next cycle; clear both counters; go to SEND. tx_rdy drops in the same cycle ld rises.
  - SEND:
    - The bit-time counter increments 0..BIT_TIME-1.
    - At BIT_TIME-1: the counter wraps to 0, shift pulses for one cycle, and the bit counter increments.
    - When the bit counter reaches 11 (all 11 bit times elapsed): go to DONE.
  - DONE:
    - Single cycle; tx_done = 1; return to IDLE with tx_rdy = 1 in the following cycle.
- Timing:
  - Latency from the ld cycle to the first shift = BIT_TIME cycles.
  - Total from tx_start to tx_done = 1 + 11*BIT_TIME + 1 cycles.
- ld and shift are never high in the same cycle.
- tx_start while not IDLE is ignored; no queueing.
- tx_data, eight, pen and ohel are sampled only in the acceptance cycle. Later changes do not alter the frame in flight.
- Back-to-back operation: tx_start asserted in the first IDLE cycle after DONE is accepted normally.
- Bit-time counter wrap is exact modulo BIT_TIME. The counter never exceeds BIT_TIME-1.

Optional Feature:
UART_PARITY_EN
- Defined: pen and ohel behave as above.
- Not defined: the parity logic is removed. P is forced to 1, so parity degenerates to a second stop (mark) bit. The pen and ohel ports remain present but are ignored. Frame timing and length are unchanged at 11 bit times.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME_W = 11, DATA_W = 8, IDLE_FRAME = 11'h7FF.
  - State enum {IDLE, SEND, DONE}.
  - Function build_frame(data, eight, pen, ohel).
- The receive side reuses the same package.
- One sub-module, uart_bit_timer: a parameterised modulo-BIT_TIME counter with enable and clear, outputting a one-cycle tick at the terminal count. The FSM and bit counter stay in uart_tx_ctrl.

Test Plan:
1. Reset mid-SEND (reset low for 1 cycle at cycle 20) -> frame = 7FF, tx_rdy = 1, no tx_done; a subsequent tx_start sends normally.
2. BIT_TIME=4; tx_start with tx_data=8'hA5, eight=1, pen=1, ohel=0 -> frame = 11'b1_0_10100101_0; ld for 1 cycle; 11 shift pulses spaced 4 cycles apart; tx_done 46 cycles after tx_start.
3. Same data with ohel=1 -> P = 1 (frame 11'b1_1_10100101_0). With pen=0 -> P = 1. Without UART_PARITY_EN, P = 1 regardless of pen and ohel.
4. eight=0, tx_data=8'hFF, pen=1, ohel=0 -> frame = 11'b1_1_1_1111111_0 (7 ones, even parity P = 1); tx_data[7] has no effect.
5. tx_start held high continuously -> exactly one frame per ld; tx_start ignored during SEND; the next ld occurs 2 cycles after tx_done, with the transmitter back in IDLE.
6. Change tx_data from A5 to 3C one cycle after acceptance -> frame in flight still encodes A5; ld and shift never coincide over the whole run.
